bit_debouncer: RTL and testbench

Upstream conditioning stage for try1's single-bit input `i`. It takes an asynchronous raw input, synchronises it, and rejects pulses shorter than a programmable stable time. It drives a clean level (`level_o`, wired to try1 `i`), one-cycle rise/fall pulses, and a saturating count of rejected glitches for debug.

---
 rtl/bit_debouncer_pkg.sv | 6 +
 rtl/bit_debouncer_if.sv | 13 +
 rtl/bit_debouncer_sync.sv | 16 +
 rtl/bit_debouncer.sv | 98 +++++++++
 tb/tb_bit_debouncer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/bit_debouncer_pkg.sv
// debounce_pkg: shared state encoding and glitch counter sizing for the debouncer
package debounce_pkg;
  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;
  localparam int GLITCH_W = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'hFF;
endpackage

// File: rtl/bit_debouncer_if.sv
// bit_debouncer_if: raw input, glitch clear and conditioned outputs of the debouncer
interface bit_debouncer_if;
  import debounce_pkg::*;
  logic raw_in;
  logic glitch_clr;
  logic level_o;
  logic rise_o;
  logic fall_o;
  logic busy_o;
  logic [GLITCH_W-1:0] glitch_cnt_o;
  modport master(output raw_in, glitch_clr, input level_o, rise_o, fall_o, busy_o, glitch_cnt_o);
  modport slave(input raw_in, glitch_clr, output level_o, rise_o, fall_o, busy_o, glitch_cnt_o);
endinterface

// File: rtl/bit_debouncer_sync.sv
// bit_sync: reusable multi-flop synchroniser for an asynchronous single-bit input
module bit_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or posedge rst)
    if (rst) ff <= {STAGES{RESET_VAL}};
    else     ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/bit_debouncer.sv
// bit_debouncer: synchronises raw_in and only accepts levels stable for STABLE_CYCLES samples
module bit_debouncer
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input logic clk,
  input logic rst,
  bit_debouncer_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam bit FAST = STABLE_CYCLES == 1;
  logic s;
  logic abort;
  state_t state;
  logic [CW-1:0] cnt;
  logic level, rise, fall, busy;
  logic [GLITCH_W-1:0] glitch;
  bit_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(RESET_LEVEL)) u_sync (
    .clk(clk), .rst(rst), .d(bus.raw_in), .q(s)
  );
  assign abort = (state == WAIT_HI && !s) || (state == WAIT_LO && s);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RESET_LEVEL ? IDLE_HI : IDLE_LO;
      cnt   <= '0;
      level <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE_LO:
          if (s) begin
            if (FAST) begin
              state <= IDLE_HI;
              level <= 1'b1;
              rise  <= 1'b1;
            end else begin
              state <= WAIT_HI;
              cnt   <= CW'(1);
              busy  <= 1'b1;
            end
          end
        WAIT_HI:
          if (!s) begin
            state <= IDLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == LAST) begin
            state <= IDLE_HI;
            level <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
            busy  <= 1'b0;
          end else cnt <= cnt + 1'b1;
        IDLE_HI:
          if (!s) begin
            if (FAST) begin
              state <= IDLE_LO;
              level <= 1'b0;
              fall  <= 1'b1;
            end else begin
              state <= WAIT_LO;
              cnt   <= CW'(1);
              busy  <= 1'b1;
            end
          end
        WAIT_LO:
          if (s) begin
            state <= IDLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == LAST) begin
            state <= IDLE_LO;
            level <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
            busy  <= 1'b0;
          end else cnt <= cnt + 1'b1;
      endcase
    end
  // clear takes priority so a glitch aborting in the clear cycle is dropped
  always_ff @(posedge clk or posedge rst)
    if (rst)                                glitch <= '0;
    else if (bus.glitch_clr)                glitch <= '0;
    else if (abort && glitch != GLITCH_MAX) glitch <= glitch + 1'b1;
  assign bus.level_o      = level;
  assign bus.rise_o       = rise;
  assign bus.fall_o       = fall;
  assign bus.busy_o       = busy;
  assign bus.glitch_cnt_o = glitch;
endmodule

// File: tb/tb_bit_debouncer.sv
// tb_bit_debouncer: run-length reference model, stimulus table and corner-case sequences
module tb_bit_debouncer;
  import debounce_pkg::*;
  localparam int SYNC = 2;
  localparam int STABLE = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bit_debouncer_if a();
  bit_debouncer_if b();
  bit_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .RESET_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(a)
  );
  bit_debouncer #(.SYNC_STAGES(3), .STABLE_CYCLES(1), .RESET_LEVEL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(b)
  );
  typedef struct {
    bit raw;
    int cycles;
    bit level;
    int glitch;
  } vec_t;
  vec_t tbl[8];
  int n_cmp = 0;
  int n_err = 0;
  bit hist[$];
  int run, m_glitch;
  bit m_level, m_rise, m_fall, m_busy;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (SYNC) hist.push_back(1'b0);
    run = 0; m_glitch = 0; m_level = 0; m_rise = 0; m_fall = 0; m_busy = 0;
  endtask

  // a new level is accepted after STABLE consecutive differing samples; any break aborts
  task automatic model_step(bit raw, bit clr);
    bit s, ab;
    s = hist.pop_front();
    hist.push_back(raw);
    m_rise = 0; m_fall = 0; ab = 0;
    if (s != m_level) begin
      run++;
      if (run == STABLE) begin
        m_level = s; m_rise = s; m_fall = !s; run = 0;
      end
    end else begin
      ab = run > 0;
      run = 0;
    end
    m_busy = run > 0;
    m_glitch = clr ? 0 : (ab && m_glitch < 255) ? m_glitch + 1 : m_glitch;
  endtask

  task automatic cyc(bit raw, bit clr);
    a.raw_in = raw;
    a.glitch_clr = clr;
    @(posedge clk);
    model_step(raw, clr);
    #1;
    chk("level", a.level_o, m_level);
    chk("rise", a.rise_o, m_rise);
    chk("fall", a.fall_o, m_fall);
    chk("busy", a.busy_o, m_busy);
    chk("glitch", a.glitch_cnt_o, m_glitch[7:0]);
    chk("b_busy", b.busy_o, 0);
    chk("b_rise_fall", b.rise_o & b.fall_o, 0);
    @(negedge clk);
  endtask

  task automatic chk_rst();
    chk("rst_level", a.level_o, 0);
    chk("rst_rise", a.rise_o, 0);
    chk("rst_fall", a.fall_o, 0);
    chk("rst_busy", a.busy_o, 0);
    chk("rst_glitch", a.glitch_cnt_o, 0);
    chk("rst_b_level", b.level_o, 1);
    chk("rst_b_busy", b.busy_o, 0);
  endtask

  task automatic rst_pulse(int n);
    rst = 1'b1;
    #1 chk_rst();
    repeat (n) begin
      @(negedge clk);
      chk_rst();
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic qualify();
    int first, nr, nb;
    first = -1; nr = 0; nb = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0);
      if (a.rise_o && first < 0) first = i;
      nr += int'(a.rise_o);
      nb += int'(a.busy_o);
    end
    chk("rise_edge", first[7:0], 17);
    chk("rise_count", nr[7:0], 1);
    chk("busy_cycles", nb[7:0], 15);
    chk("qual_level", a.level_o, 1);
  endtask

  initial begin
    int first, nf, nr;
    tbl[0] = '{1'b0, 5, 1'b1, 0};
    tbl[1] = '{1'b1, 5, 1'b1, 1};
    tbl[2] = '{1'b0, 20, 1'b0, 1};
    tbl[3] = '{1'b1, 3, 1'b0, 1};
    tbl[4] = '{1'b0, 4, 1'b0, 2};
    tbl[5] = '{1'b1, 18, 1'b1, 2};
    tbl[6] = '{1'b1, 5, 1'b1, 2};
    tbl[7] = '{1'b0, 20, 1'b0, 2};
    a.raw_in = 1'b1;
    a.glitch_clr = 1'b0;
    b.raw_in = 1'b1;
    model_reset();
    @(negedge clk);
    rst_pulse(10);
    qualify();
    for (int i = 0; i < 8; i++) begin
      repeat (tbl[i].cycles) cyc(tbl[i].raw, 1'b0);
      chk("tbl_level", a.level_o, tbl[i].level);
      chk("tbl_glitch", a.glitch_cnt_o, tbl[i].glitch[7:0]);
    end
    repeat (300) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
    end
    repeat (4) cyc(1'b0, 1'b0);
    chk("sat_glitch", a.glitch_cnt_o, 255);
    chk("sat_level", a.level_o, 0);
    cyc(1'b0, 1'b1);
    chk("clr_glitch", a.glitch_cnt_o, 0);
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    chk("one_glitch", a.glitch_cnt_o, 1);
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b1);
    chk("clr_wins", a.glitch_cnt_o, 0);
    cyc(1'b0, 1'b0);
    chk("clr_hold", a.glitch_cnt_o, 0);
    repeat (10) cyc(1'b1, 1'b0);
    chk("busy_pre_rst", a.busy_o, 1);
    rst_pulse(1);
    qualify();
    b.raw_in = 1'b0;
    first = -1; nf = 0; nr = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0);
      if (b.fall_o && first < 0) first = i;
      nf += int'(b.fall_o);
      nr += int'(b.rise_o);
    end
    chk("b_fall_edge", first[7:0], 3);
    chk("b_fall_count", nf[7:0], 1);
    chk("b_rise_count", nr[7:0], 0);
    chk("b_level", b.level_o, 0);
    repeat (150) begin
      bit v;
      int len;
      v = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 25);
      repeat (len) cyc(v, $urandom_range(0, 49) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
